// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: issues per-element work to a serial PE and buffers its results under credit control
// Ports:
//   clk, rst_n      clock and synchronous reset (active-high despite the name)
//   inst_*          instruction handshake; inst_len counts 32-element blocks
//   neuron/weight_addr, pe_vld_i, pe_ctl   element issue towards the serial PE
//   pe_result, pe_vld_o                    results coming back from the serial PE
//   res_*           result FIFO head with valid/ready pop
//   busy, err       activity indicator and sticky overflow/spurious-result flag
module pe_seq_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int RES_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_vld,
  input  logic [7:0]        inst_len,
  output logic              inst_rdy,
  output logic [ADDR_W-1:0] neuron_addr,
  output logic [ADDR_W-1:0] weight_addr,
  output logic              pe_vld_i,
  output logic [1:0]        pe_ctl,
  input  logic [31:0]       pe_result,
  input  logic              pe_vld_o,
  output logic [31:0]       res_data,
  output logic              res_vld,
  input  logic              res_rdy,
  output logic              busy,
  output logic              err
);
  localparam int CW = $clog2(RES_DEPTH + 1);
  localparam int PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0]        state_q, state_d;
  logic [12:0]       iter_q, iter_d;
  logic [7:0]        len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CW-1:0]     out_q, out_d, cnt_q, cnt_d;
  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic              err_q, err_d;
  logic [31:0]       mem_q [RES_DEPTH];
  logic              run, last, pop, full, push_ok, credit_ok, start, ret_ok;
  logic [CW:0]       used;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(RES_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction
  assign run       = state_q == RUN;
  assign last      = run && (iter_q == {len_q, 5'd0} - 13'd1);
  assign used      = {1'b0, out_q} + {1'b0, cnt_q};
  assign res_vld   = cnt_q != '0;
  assign pop       = res_vld && res_rdy;
  assign full      = cnt_q == CW'(RES_DEPTH);
  assign credit_ok = used < (CW+1)'(RES_DEPTH);
  // A back-to-back accept must also leave room for the result the finishing instruction still owes.
  assign inst_rdy  = run ? credit_ok && last &&
                     (({1'b0, used} + (CW+2)'(1)) < ((CW+2)'(RES_DEPTH) + (CW+2)'(pop)))
                         : credit_ok;
  assign start     = inst_vld && inst_rdy && (inst_len != 8'd0);
  assign push_ok   = pe_vld_o && (!full || pop);
  // A result with nothing outstanding still counts as a push but must not underflow the counter.
  assign ret_ok    = pe_vld_o && (out_q != '0);
  always_comb begin
    state_d = start ? RUN : (last ? IDLE : state_q);
    iter_d  = start ? 13'd0 : (run ? iter_q + 13'd1 : iter_q);
    len_d   = start ? inst_len : len_q;
    addr_d  = run ? addr_q + ADDR_W'(1) : addr_q;
    out_d   = out_q + CW'(last) - CW'(ret_ok);
    cnt_d   = cnt_q + CW'(push_ok) - CW'(pop);
    wr_d    = push_ok ? nxt(wr_q) : wr_q;
    rd_d    = pop ? nxt(rd_q) : rd_q;
    err_d   = err_q | (pe_vld_o && ((out_q == '0) || (full && !pop)));
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      iter_q  <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok && !rst_n) mem_q[wr_q] <= pe_result;
  end
  assign neuron_addr = addr_q;
  assign weight_addr = addr_q;
  assign pe_vld_i    = run;
  assign pe_ctl      = run ? {last, iter_q == 13'd0} : 2'b00;
  assign res_data    = res_vld ? mem_q[rd_q] : 32'd0;
  assign busy        = run || (out_q != '0) || res_vld;
  assign err         = err_q;
endmodule

// File: tb/tb_pe_seq_ctrl.sv
// tb_pe_seq_ctrl: table-driven and directed checks of pe_seq_ctrl against a PE model and result scoreboard
module tb_pe_seq_ctrl;
  logic        clk = 1'b0, rst_n = 1'b1, inst_vld = 1'b0, res_rdy = 1'b1, pe_vld_o = 1'b0;
  logic [7:0]  inst_len = 8'd0;
  logic [31:0] pe_result = 32'd0;
  logic        inst_rdy, pe_vld_i, res_vld, busy, err;
  logic [15:0] neuron_addr, weight_addr;
  logic [1:0]  pe_ctl;
  logic [31:0] res_data;
  always #5 clk = ~clk;
  pe_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .inst_vld(inst_vld), .inst_len(inst_len), .inst_rdy(inst_rdy),
    .neuron_addr(neuron_addr), .weight_addr(weight_addr), .pe_vld_i(pe_vld_i), .pe_ctl(pe_ctl),
    .pe_result(pe_result), .pe_vld_o(pe_vld_o), .res_data(res_data), .res_vld(res_vld),
    .res_rdy(res_rdy), .busy(busy), .err(err)
  );
  typedef struct {
    int          n;
    logic [31:0] lens;
    int          lat;
    int          exp_issue;
    int          exp_res;
    logic        exp_contig;
  } vec_t;
  vec_t        tbl [5];
  int          checks = 0, fails = 0;
  int          cyc = 0, lat = 1, elem = 0, rnum = 0;
  int          issues = 0, pops = 0, first_iss = 0, last_iss = 0, accepts = 0;
  int          feed_n = 0, k = 0;
  logic [31:0] feed_lens = 32'd0;
  logic [15:0] exp_addr = 16'd0;
  logic        spur = 1'b0, acc_seen = 1'b0, done = 1'b0;
  int          lens_q [$];
  int          due [$];
  logic [31:0] sb [$];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic monitor();
    int l;
    if (rst_n) begin
      exp_addr = 16'd0;
      elem = 0;
      lens_q.delete();
      due.delete();
      sb.delete();
      return;
    end
    if (pe_vld_i) begin
      chk("issue_has_inst", 64'(lens_q.size() > 0), 64'd1);
      if (lens_q.size() > 0) begin
        l = lens_q[0] * 32 - 1;
        chk("neuron_addr", 64'(neuron_addr), 64'(exp_addr));
        chk("weight_addr", 64'(weight_addr), 64'(exp_addr));
        chk("pe_ctl", 64'(pe_ctl), 64'({elem == l, elem == 0}));
        if (issues == 0) first_iss = cyc;
        last_iss = cyc;
        issues++;
        exp_addr++;
        if (elem == l) begin
          void'(lens_q.pop_front());
          elem = 0;
          due.push_back(cyc + lat);
        end else elem++;
      end
    end
    if (inst_vld && inst_rdy) begin
      accepts++;
      acc_seen = 1'b1;
      if (inst_len != 8'd0) lens_q.push_back(int'(inst_len));
    end
    if (res_vld && res_rdy) begin
      pops++;
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL res_unexpected: got %0h expected no result", res_data);
      end else begin
        logic [31:0] e = sb.pop_front();
        if (res_data !== e) begin
          fails++;
          $display("FAIL res_data: got %0h expected %0h", res_data, e);
        end
      end
    end
  endtask
  task automatic drive_pe();
    cyc++;
    pe_vld_o = 1'b0;
    if (spur || (due.size() > 0 && due[0] <= cyc)) begin
      if (!spur) void'(due.pop_front());
      spur = 1'b0;
      rnum++;
      pe_result = 32'hC0DE_0000 + 32'(rnum);
      pe_vld_o = 1'b1;
      sb.push_back(pe_result);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    drive_pe();
  endtask
  task automatic ftick();
    tick();
    if (acc_seen) begin
      acc_seen = 1'b0;
      k++;
      if (k < feed_n) inst_len = feed_lens[8*k +: 8];
      else inst_vld = 1'b0;
    end
  endtask
  task automatic start_feed(input int n, input logic [31:0] lens);
    feed_n = n;
    feed_lens = lens;
    k = 0;
    acc_seen = 1'b0;
    inst_len = lens[7:0];
    inst_vld = 1'b1;
  endtask
  task automatic clear_stats();
    issues = 0; pops = 0; accepts = 0; first_iss = 0; last_iss = 0;
  endtask
  task automatic do_reset();
    rst_n = 1'b1;
    inst_vld = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    clear_stats();
  endtask
  task automatic run_to_done(input int max);
    done = 1'b0;
    for (int c = 0; c < max && !done; c++) begin
      ftick();
      done = (k == feed_n) && lens_q.size() == 0 && due.size() == 0 && sb.size() == 0 && !busy;
    end
    chk("scenario_done", 64'(done), 64'd1);
  endtask
  initial begin
    tbl[0] = '{n: 1, lens: 32'h0000_0001, lat: 3,  exp_issue: 32,  exp_res: 1, exp_contig: 1'b1};
    tbl[1] = '{n: 4, lens: 32'h0301_0201, lat: 1,  exp_issue: 224, exp_res: 4, exp_contig: 1'b1};
    tbl[2] = '{n: 3, lens: 32'h0001_0001, lat: 1,  exp_issue: 64,  exp_res: 2, exp_contig: 1'b0};
    tbl[3] = '{n: 1, lens: 32'h0000_0003, lat: 5,  exp_issue: 96,  exp_res: 1, exp_contig: 1'b1};
    tbl[4] = '{n: 3, lens: 32'h0001_0101, lat: 40, exp_issue: 96,  exp_res: 3, exp_contig: 1'b0};
    repeat (3) tick();
    chk("rst_inst_rdy", 64'(inst_rdy), 64'd1);
    chk("rst_pe_vld_i", 64'(pe_vld_i), 64'd0);
    chk("rst_pe_ctl", 64'(pe_ctl), 64'd0);
    chk("rst_res_vld", 64'(res_vld), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_addr", 64'(neuron_addr), 64'd0);
    rst_n = 1'b0;
    tick();
    chk("post_rst_inst_rdy", 64'(inst_rdy), 64'd1);
    chk("post_rst_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 5; i++) begin
      do_reset();
      lat = tbl[i].lat;
      res_rdy = 1'b1;
      start_feed(tbl[i].n, tbl[i].lens);
      run_to_done(3000);
      chk($sformatf("v%0d_issues", i), 64'(issues), 64'(tbl[i].exp_issue));
      chk($sformatf("v%0d_results", i), 64'(pops), 64'(tbl[i].exp_res));
      chk($sformatf("v%0d_accepts", i), 64'(accepts), 64'(tbl[i].n));
      chk($sformatf("v%0d_contig", i), 64'(last_iss - first_iss + 1 == issues), 64'(tbl[i].exp_contig));
      chk($sformatf("v%0d_err", i), 64'(err), 64'd0);
    end
    do_reset();
    lat = 1;
    res_rdy = 1'b0;
    start_feed(3, 32'h0001_0101);
    repeat (150) ftick();
    chk("credit_accepts", 64'(k), 64'd2);
    chk("credit_inst_rdy", 64'(inst_rdy), 64'd0);
    chk("credit_res_vld", 64'(res_vld), 64'd1);
    chk("credit_err", 64'(err), 64'd0);
    res_rdy = 1'b1;
    ftick();
    res_rdy = 1'b0;
    for (int c = 0; c < 20 && k < 3; c++) ftick();
    chk("credit_third_accept", 64'(k), 64'd3);
    repeat (60) ftick();
    chk("credit_err_held", 64'(err), 64'd0);
    res_rdy = 1'b1;
    run_to_done(200);
    chk("credit_results", 64'(pops), 64'd3);
    do_reset();
    start_feed(1, 32'h0000_0002);
    done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      ftick();
      done = pe_vld_i && neuron_addr == 16'd10;
    end
    chk("abort_reached_iter10", 64'(done), 64'd1);
    rst_n = 1'b1;
    ftick();
    chk("abort_pe_vld_i", 64'(pe_vld_i), 64'd0);
    chk("abort_neuron_addr", 64'(neuron_addr), 64'd0);
    chk("abort_weight_addr", 64'(weight_addr), 64'd0);
    chk("abort_res_vld", 64'(res_vld), 64'd0);
    rst_n = 1'b0;
    clear_stats();
    start_feed(1, 32'h0000_0001);
    run_to_done(200);
    chk("restart_issues", 64'(issues), 64'd32);
    chk("restart_results", 64'(pops), 64'd1);
    do_reset();
    res_rdy = 1'b1;
    spur = 1'b1;
    tick();
    tick();
    chk("spur_err", 64'(err), 64'd1);
    repeat (5) tick();
    chk("spur_err_sticky", 64'(err), 64'd1);
    chk("spur_result_passed", 64'(pops), 64'd1);
    rst_n = 1'b1;
    tick();
    chk("spur_err_cleared", 64'(err), 64'd0);
    rst_n = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
